// File: rtl/accelerator_vector_multiplier_arbiter.sv
// Round-robin arbiter sharing one vector multiplier between four requesters.
// The owner's operand slot is muxed onto the multiplier; products are broadcast, strobes routed to the owner.
module accelerator_vector_multiplier_arbiter #(
    parameter int unsigned DATA_SIZE    = 64,
    parameter int unsigned CONTROL_SIZE = 64
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [3:0]             REQ,
    output logic [3:0]             GNT,
    output logic [3:0]             DONE,
    input  logic [4*DATA_SIZE-1:0] SIZE_IN,
    input  logic [4*DATA_SIZE-1:0] DATA_A_IN,
    input  logic [4*DATA_SIZE-1:0] DATA_B_IN,
    input  logic [3:0]             DATA_A_IN_ENABLE,
    input  logic [3:0]             DATA_B_IN_ENABLE,
    output logic [DATA_SIZE-1:0]   DATA_OUT,
    output logic [3:0]             DATA_OUT_ENABLE,
    output logic                   MUL_START,
    input  logic                   MUL_READY,
    output logic [DATA_SIZE-1:0]   MUL_SIZE,
    output logic [DATA_SIZE-1:0]   MUL_DATA_A,
    output logic [DATA_SIZE-1:0]   MUL_DATA_B,
    output logic                   MUL_DATA_A_ENABLE,
    output logic                   MUL_DATA_B_ENABLE,
    input  logic [DATA_SIZE-1:0]   MUL_DATA_OUT,
    input  logic                   MUL_DATA_OUT_ENABLE
);

    // A vector length is a loop count, so only the control-width bits decide "empty".
    localparam int unsigned SizeW = (CONTROL_SIZE < DATA_SIZE) ? CONTROL_SIZE : DATA_SIZE;

    typedef enum logic [1:0] {IDLE, GRANT, BUSY, RELEASE} state_t;

    state_t                 state_q;
    logic [1:0]             ptr_q;
    logic [1:0]             owner_q;
    logic [3:0]             gnt_q;
    logic [3:0]             done_q;
    logic                   start_q;
    logic [DATA_SIZE-1:0]   size_q;

    logic                   win_found_d;
    logic [1:0]             win_idx_d;
    logic [1:0]             cand_d;
    logic [DATA_SIZE-1:0]   owner_size_d;
    logic [DATA_SIZE-1:0]   owner_a_d;
    logic [DATA_SIZE-1:0]   owner_b_d;

    // Round-robin search starting at ptr_q; first hit wins.
    always_comb begin
        win_found_d = 1'b0;
        win_idx_d   = ptr_q;
        cand_d      = ptr_q;
        for (int unsigned i = 0; i < 4; i++) begin
            cand_d = ptr_q + 2'(i);
            if (!win_found_d && REQ[cand_d]) begin
                win_found_d = 1'b1;
                win_idx_d   = cand_d;
            end
        end
    end

    always_comb begin
        owner_size_d = '0;
        owner_a_d    = '0;
        owner_b_d    = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (owner_q == 2'(i)) begin
                owner_size_d = SIZE_IN[i*DATA_SIZE +: DATA_SIZE];
                owner_a_d    = DATA_A_IN[i*DATA_SIZE +: DATA_SIZE];
                owner_b_d    = DATA_B_IN[i*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            start_q <= 1'b0;
            size_q  <= '0;
        end else begin
            done_q  <= '0;
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_found_d) begin
                        gnt_q   <= 4'b0001 << win_idx_d;
                        owner_q <= win_idx_d;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    size_q <= owner_size_d;
                    if (owner_size_d[SizeW-1:0] != '0) begin
                        start_q <= 1'b1;
                        state_q <= BUSY;
                    end else begin
                        state_q <= RELEASE;
                    end
                end
                BUSY: begin
                    if (MUL_READY) state_q <= RELEASE;
                end
                RELEASE: begin
                    done_q  <= gnt_q;
                    gnt_q   <= '0;
                    ptr_q   <= owner_q + 2'd1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign GNT               = gnt_q;
    assign DONE              = done_q;
    assign MUL_START         = start_q;
    assign MUL_SIZE          = size_q;
    assign MUL_DATA_A        = (gnt_q != '0) ? owner_a_d : '0;
    assign MUL_DATA_B        = (gnt_q != '0) ? owner_b_d : '0;
    assign MUL_DATA_A_ENABLE = |(gnt_q & DATA_A_IN_ENABLE);
    assign MUL_DATA_B_ENABLE = |(gnt_q & DATA_B_IN_ENABLE);
    assign DATA_OUT          = MUL_DATA_OUT;
    assign DATA_OUT_ENABLE   = gnt_q & {4{MUL_DATA_OUT_ENABLE}};

endmodule

// File: tb/tb_accelerator_vector_multiplier_arbiter.sv
// Bench for the multiplier arbiter: behavioural multiplier plus a product scoreboard.
module tb_accelerator_vector_multiplier_arbiter;

    localparam int unsigned DW = 64;

    logic            CLK = 1'b0;
    logic            RST;
    logic [3:0]      REQ;
    logic [3:0]      GNT;
    logic [3:0]      DONE;
    logic [4*DW-1:0] SIZE_IN;
    logic [4*DW-1:0] DATA_A_IN;
    logic [4*DW-1:0] DATA_B_IN;
    logic [3:0]      A_EN;
    logic [3:0]      B_EN;
    logic [DW-1:0]   DATA_OUT;
    logic [3:0]      DATA_OUT_ENABLE;
    logic            MUL_START;
    logic            MUL_READY;
    logic [DW-1:0]   MUL_SIZE;
    logic [DW-1:0]   MUL_DATA_A;
    logic [DW-1:0]   MUL_DATA_B;
    logic            MUL_DATA_A_ENABLE;
    logic            MUL_DATA_B_ENABLE;
    logic [DW-1:0]   MUL_DATA_OUT;
    logic            MUL_DATA_OUT_ENABLE;

    accelerator_vector_multiplier_arbiter #(.DATA_SIZE(DW), .CONTROL_SIZE(64)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .GNT(GNT), .DONE(DONE),
        .SIZE_IN(SIZE_IN), .DATA_A_IN(DATA_A_IN), .DATA_B_IN(DATA_B_IN),
        .DATA_A_IN_ENABLE(A_EN), .DATA_B_IN_ENABLE(B_EN),
        .DATA_OUT(DATA_OUT), .DATA_OUT_ENABLE(DATA_OUT_ENABLE),
        .MUL_START(MUL_START), .MUL_READY(MUL_READY), .MUL_SIZE(MUL_SIZE),
        .MUL_DATA_A(MUL_DATA_A), .MUL_DATA_B(MUL_DATA_B),
        .MUL_DATA_A_ENABLE(MUL_DATA_A_ENABLE), .MUL_DATA_B_ENABLE(MUL_DATA_B_ENABLE),
        .MUL_DATA_OUT(MUL_DATA_OUT), .MUL_DATA_OUT_ENABLE(MUL_DATA_OUT_ENABLE)
    );

    always #5 CLK = ~CLK;

    // Multiplier: latches length on START, one product per operand pair, READY with the last product.
    logic [DW-1:0] rem;
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            rem <= '0; MUL_DATA_OUT <= '0; MUL_DATA_OUT_ENABLE <= 1'b0; MUL_READY <= 1'b0;
        end else begin
            MUL_DATA_OUT_ENABLE <= 1'b0;
            MUL_READY <= 1'b0;
            if (MUL_START) rem <= MUL_SIZE;
            else if (MUL_DATA_A_ENABLE && MUL_DATA_B_ENABLE) begin
                MUL_DATA_OUT <= MUL_DATA_A * MUL_DATA_B;
                MUL_DATA_OUT_ENABLE <= 1'b1;
                rem <= rem - 1;
                if (rem == 1) MUL_READY <= 1'b1;
            end
        end
    end

    typedef struct packed {
        logic [DW-1:0] prod;
        logic [3:0]    oe;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] grant_log[$];
    int         tests = 0;
    int         fails = 0;
    int         start_cnt = 0;
    int         done_cnt = 0;
    int         oe_cnt[4] = '{0, 0, 0, 0};
    bit         overlap = 1'b0;

    initial begin : monitor
        exp_t       e;
        logic [3:0] prev_gnt;
        prev_gnt = '0;
        forever begin
            @(negedge CLK);
            if (DATA_OUT_ENABLE != '0) begin
                for (int i = 0; i < 4; i++) if (DATA_OUT_ENABLE[i]) oe_cnt[i]++;
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL product_unexpected: DATA_OUT_ENABLE=%b, required no product", DATA_OUT_ENABLE);
                end else begin
                    e = sb.pop_front();
                    if (DATA_OUT !== e.prod || DATA_OUT_ENABLE !== e.oe) begin
                        fails++;
                        $display("FAIL product: DATA_OUT=%h OE=%b, required %h OE=%b",
                                 DATA_OUT, DATA_OUT_ENABLE, e.prod, e.oe);
                    end
                end
            end
            if (MUL_START === 1'b1) start_cnt++;
            if (DONE != '0) done_cnt++;
            if (GNT != '0 && prev_gnt == '0) grant_log.push_back(GNT);
            if ($countones(GNT) > 1) overlap = 1'b1;
            prev_gnt = GNT;
        end
    end

    function automatic logic [DW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic wait_gnt(input logic [3:0] exp, input string nm);
        int n = 0;
        while (GNT !== exp && n < 50) begin tick(); n++; end
        tests++;
        if (GNT !== exp) begin
            fails++;
            $display("FAIL %s: GNT=%b, required %b within 50 cycles", nm, GNT, exp);
        end
    endtask

    task automatic wait_done(output logic [3:0] d);
        int n = 0;
        while (DONE == '0 && n < 50) begin tick(); n++; end
        d = DONE;
    endtask

    task automatic drive_pair(input int unsigned r, input logic [DW-1:0] a, input logic [DW-1:0] b);
        exp_t x;
        DATA_A_IN[r*DW +: DW] = a;
        DATA_B_IN[r*DW +: DW] = b;
        A_EN[r] = 1'b1;
        B_EN[r] = 1'b1;
        x.prod = a * b;
        x.oe   = 4'b0001 << r;
        sb.push_back(x);
        tick();
        A_EN[r] = 1'b0;
        B_EN[r] = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; REQ = '0; SIZE_IN = '0; DATA_A_IN = '0; DATA_B_IN = '0; A_EN = '0; B_EN = '0;
        #12;
        tests++;
        if (GNT !== 4'b0 || DONE !== 4'b0 || MUL_START !== 1'b0 || MUL_SIZE !== '0) begin
            fails++;
            $display("FAIL reset_state: GNT=%b DONE=%b START=%b SIZE=%h, required all zero",
                     GNT, DONE, MUL_START, MUL_SIZE);
        end
        tests++;
        if (MUL_DATA_A_ENABLE !== 1'b0 || MUL_DATA_B_ENABLE !== 1'b0 || DATA_OUT_ENABLE !== 4'b0) begin
            fails++;
            $display("FAIL reset_enables: A_EN=%b B_EN=%b OE=%b, required 0",
                     MUL_DATA_A_ENABLE, MUL_DATA_B_ENABLE, DATA_OUT_ENABLE);
        end
        tick();
        RST = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [3:0] d;
        int s0 = start_cnt, d0 = done_cnt, o0 = oe_cnt[0];
        SIZE_IN[0*DW +: DW] = 3;
        REQ = 4'b0001;
        wait_gnt(4'b0001, "single_gnt");
        tick();
        tests++;
        if (MUL_START !== 1'b1 || MUL_SIZE !== 64'd3) begin
            fails++;
            $display("FAIL single_start: START=%b SIZE=%0d, required 1 and 3", MUL_START, MUL_SIZE);
        end
        tick();
        for (int i = 0; i < 3; i++) drive_pair(0, rnd64(), rnd64());
        wait_done(d);
        REQ = '0;
        tests++;
        if (d !== 4'b0001) begin
            fails++;
            $display("FAIL single_done: DONE=%b, required 0001", d);
        end
        repeat (3) tick();
        tests++;
        if (start_cnt - s0 != 1 || done_cnt - d0 != 1 || oe_cnt[0] - o0 != 3 || sb.size() != 0 || GNT !== 4'b0) begin
            fails++;
            $display("FAIL single_counts: starts=%0d dones=%0d products=%0d pending=%0d GNT=%b, required 1 1 3 0 0000",
                     start_cnt - s0, done_cnt - d0, oe_cnt[0] - o0, sb.size(), GNT);
        end
        // Pointer should now favour requester 1 over requester 0.
        SIZE_IN[0*DW +: DW] = 0;
        SIZE_IN[1*DW +: DW] = 0;
        REQ = 4'b0011;
        wait_gnt(4'b0010, "single_ptr_next");
        wait_done(d);
        REQ = '0;
        repeat (2) tick();
    endtask

    task automatic test_zero_len();
        int s0 = start_cnt;
        SIZE_IN[2*DW +: DW] = 0;
        REQ = 4'b0100;
        wait_gnt(4'b0100, "zero_gnt");
        tick();
        tests++;
        if (DONE !== 4'b0) begin
            fails++;
            $display("FAIL zero_done_early: DONE=%b, required 0000 one cycle after grant", DONE);
        end
        tick();
        tests++;
        if (DONE !== 4'b0100 || GNT !== 4'b0) begin
            fails++;
            $display("FAIL zero_done: DONE=%b GNT=%b, required 0100 and 0000", DONE, GNT);
        end
        REQ = '0;
        repeat (2) tick();
        tests++;
        if (start_cnt != s0) begin
            fails++;
            $display("FAIL zero_no_start: starts=%0d, required 0", start_cnt - s0);
        end
    endtask

    task automatic test_isolation();
        logic [3:0]    d;
        logic [DW-1:0] a, b;
        exp_t          x;
        int            o3 = oe_cnt[3];
        SIZE_IN[1*DW +: DW] = 2;
        REQ = 4'b1010;
        REQ[3] = 1'b0;
        REQ = 4'b0010;
        wait_gnt(4'b0010, "iso_gnt");
        repeat (2) tick();
        a = rnd64(); b = rnd64();
        DATA_A_IN[1*DW +: DW] = a;
        DATA_B_IN[1*DW +: DW] = b;
        DATA_A_IN[3*DW +: DW] = 64'hDEAD;
        A_EN = 4'b1000;
        #1;
        tests++;
        if (MUL_DATA_A_ENABLE !== 1'b0 || MUL_DATA_A !== a) begin
            fails++;
            $display("FAIL iso_foreign_strobe: A_EN=%b A=%h, required 0 and %h", MUL_DATA_A_ENABLE, MUL_DATA_A, a);
        end
        tick();
        A_EN = 4'b1010;
        B_EN = 4'b0010;
        x.prod = a * b; x.oe = 4'b0010;
        sb.push_back(x);
        #1;
        tests++;
        if (MUL_DATA_A_ENABLE !== 1'b1 || MUL_DATA_A !== a || MUL_DATA_B !== b) begin
            fails++;
            $display("FAIL iso_owner_strobe: A_EN=%b A=%h B=%h, required 1 %h %h",
                     MUL_DATA_A_ENABLE, MUL_DATA_A, MUL_DATA_B, a, b);
        end
        tick();
        A_EN = 4'b0000; B_EN = 4'b0000;
        drive_pair(1, rnd64(), rnd64());
        wait_done(d);
        REQ = '0;
        tests++;
        if (d !== 4'b0010) begin
            fails++;
            $display("FAIL iso_done: DONE=%b, required 0010", d);
        end
        repeat (2) tick();
        tests++;
        if (oe_cnt[3] != o3 || sb.size() != 0) begin
            fails++;
            $display("FAIL iso_no_leak: OE3 pulses=%0d pending=%0d, required 0 0", oe_cnt[3] - o3, sb.size());
        end
    endtask

    task automatic test_reset_mid_busy();
        logic [3:0] d;
        int         d0;
        SIZE_IN[2*DW +: DW] = 4;
        REQ = 4'b0100;
        wait_gnt(4'b0100, "rst_gnt");
        repeat (2) tick();
        drive_pair(2, rnd64(), rnd64());
        repeat (2) tick();
        d0 = done_cnt;
        RST = 1'b1;
        SIZE_IN[2*DW +: DW] = 1;
        #1;
        tests++;
        if (GNT !== 4'b0 || DONE !== 4'b0 || MUL_START !== 1'b0 || MUL_SIZE !== '0) begin
            fails++;
            $display("FAIL rst_async: GNT=%b DONE=%b START=%b SIZE=%h, required all zero",
                     GNT, DONE, MUL_START, MUL_SIZE);
        end
        tick();
        RST = 1'b0;
        wait_gnt(4'b0100, "rst_regrant");
        repeat (2) tick();
        drive_pair(2, rnd64(), rnd64());
        wait_done(d);
        REQ = '0;
        tests++;
        if (d !== 4'b0100) begin
            fails++;
            $display("FAIL rst_done_after: DONE=%b, required 0100", d);
        end
        repeat (2) tick();
        tests++;
        if (done_cnt - d0 != 1 || sb.size() != 0) begin
            fails++;
            $display("FAIL rst_abandon: dones=%0d pending=%0d, required 1 0", done_cnt - d0, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] d;
        logic [3:0] want;
        int         order[5] = '{0, 1, 2, 3, 0};
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int i = 0; i < 4; i++) SIZE_IN[i*DW +: DW] = 1;
        grant_log.delete();
        overlap = 1'b0;
        REQ = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            want = 4'b0001 << order[k];
            wait_gnt(want, "b2b_gnt");
            repeat (2) tick();
            drive_pair(order[k], rnd64(), rnd64());
            wait_done(d);
            if (k == 4) REQ = '0;
            tests++;
            if (d !== want) begin
                fails++;
                $display("FAIL b2b_done: step %0d DONE=%b, required %b", k, d, want);
            end
        end
        repeat (2) tick();
        tests++;
        if (grant_log.size() != 5 || overlap) begin
            fails++;
            $display("FAIL b2b_log: grants=%0d overlap=%0d, required 5 0", grant_log.size(), overlap);
        end else begin
            for (int k = 0; k < 5; k++) begin
                want = 4'b0001 << order[k];
                tests++;
                if (grant_log[k] !== want) begin
                    fails++;
                    $display("FAIL b2b_order: grant %0d = %b, required %b", k, grant_log[k], want);
                end
            end
        end
    endtask

    task automatic test_drop();
        logic [3:0] d;
        SIZE_IN[0*DW +: DW] = 2;
        SIZE_IN[1*DW +: DW] = 0;
        REQ = 4'b0001;
        wait_gnt(4'b0001, "drop_gnt");
        repeat (2) tick();
        REQ = 4'b0010;
        for (int i = 0; i < 2; i++) begin
            drive_pair(0, rnd64(), rnd64());
            tests++;
            if (GNT !== 4'b0001) begin
                fails++;
                $display("FAIL drop_hold: GNT=%b, required 0001", GNT);
            end
        end
        wait_done(d);
        tests++;
        if (d !== 4'b0001) begin
            fails++;
            $display("FAIL drop_done0: DONE=%b, required 0001", d);
        end
        wait_gnt(4'b0010, "drop_next_gnt");
        wait_done(d);
        REQ = '0;
        tests++;
        if (d !== 4'b0010) begin
            fails++;
            $display("FAIL drop_done1: DONE=%b, required 0010", d);
        end
        repeat (2) tick();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drop_drain: pending products=%0d, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_len();
        test_isolation();
        test_reset_mid_busy();
        test_back_to_back();
        test_drop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion before 200000");
        $fatal(1);
    end

endmodule
